braille_sequencer: RTL and testbench

BRAILLE_SEQUENCER -- requirements
Module: braille_sequencer

---
 rtl/braille_pkg.sv | 13 +
 rtl/braille_sequencer_key_pulse.sv | 27 ++
 rtl/braille_sequencer.sv | 130 +++++++++++++
 tb/tb_braille_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/braille_pkg.sv
// Shared types and constants for the Braille message sequencer.
package braille_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    PLAY,
    DONE
  } state_t;

  localparam int CELL_W    = 6;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/braille_sequencer_key_pulse.sv
// Pushbutton synchronizer with press-edge (1 to 0) one-cycle pulse.
module key_pulse (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_n,
  output logic pulse
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      prev  <= s2;
      pulse <= prev & ~s2;
    end
  end

endmodule

// File: rtl/braille_sequencer.sv
// Stores Braille cells from switches and plays them back one per step.
module braille_sequencer
  import braille_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [CELL_W-1:0] SW,
  input  logic              KEY_STORE,
  input  logic              KEY_PLAY,
  output logic [CELL_W-1:0] cell_out,
  output logic              cell_valid,
  output logic [3:0]        fill_count,
  output logic              playing,
  output logic              full,
  output logic              empty
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LOAD     = CW'(STEP_CYCLES - 1);
  localparam logic [3:0]    DEPTH_M1 = 4'(DEPTH - 1);

  logic              store_p;
  logic              play_p;
  state_t            state;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CELL_W-1:0] mem [DEPTH];
  logic              last;
  logic              wr_en;

  key_pulse u_store (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .key_n    (KEY_STORE),
    .pulse    (store_p)
  );

  key_pulse u_play (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .key_n    (KEY_PLAY),
    .pulse    (play_p)
  );

  assign last  = (4'(rd_ptr) == fill_count - 4'd1);
  assign wr_en = (state == ENTRY) && store_p && !play_p && !full;

  // Message buffer carries no reset; only written slots are ever read.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[fill_count[AW-1:0]] <= SW;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ENTRY;
      fill_count <= 4'd0;
      rd_ptr     <= '0;
      cnt        <= '0;
      cell_out   <= '0;
      cell_valid <= 1'b0;
      playing    <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      unique case (state)
        ENTRY: begin
          cell_out   <= SW;
          cell_valid <= 1'b1;
          playing    <= 1'b0;
          if (play_p) begin
            if (!empty) begin
              state    <= PLAY;
              rd_ptr   <= '0;
              cnt      <= LOAD;
              cell_out <= mem[0];
              playing  <= 1'b1;
            end
          end else if (store_p && !full) begin
            fill_count <= fill_count + 4'd1;
            full       <= (fill_count == DEPTH_M1);
            empty      <= 1'b0;
          end
        end
        PLAY: begin
          if (play_p) begin
            state    <= ENTRY;
            cell_out <= SW;
            playing  <= 1'b0;
          end else if (cnt == '0) begin
            if (last) begin
              state      <= DONE;
              cell_out   <= '0;
              cell_valid <= 1'b0;
              playing    <= 1'b0;
            end else begin
              rd_ptr   <= rd_ptr + AW'(1);
              cnt      <= LOAD;
              cell_out <= mem[rd_ptr + AW'(1)];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (play_p) begin
            state      <= PLAY;
            rd_ptr     <= '0;
            cnt        <= LOAD;
            cell_out   <= mem[0];
            cell_valid <= 1'b1;
            playing    <= 1'b1;
          end else if (store_p) begin
            state      <= ENTRY;
            fill_count <= 4'd0;
            full       <= 1'b0;
            empty      <= 1'b1;
            cell_out   <= SW;
            cell_valid <= 1'b1;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_braille_sequencer.sv
// Directed self-checking bench for braille_sequencer (STEP_CYCLES=4, DEPTH=8).
module tb_braille_sequencer;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [5:0] SW;
  logic       KEY_STORE;
  logic       KEY_PLAY;
  logic [5:0] cell_out;
  logic       cell_valid;
  logic [3:0] fill_count;
  logic       playing;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  logic [5:0] pat [9];

  braille_sequencer #(
    .STEP_CYCLES (4),
    .DEPTH       (8)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .SW         (SW),
    .KEY_STORE  (KEY_STORE),
    .KEY_PLAY   (KEY_PLAY),
    .cell_out   (cell_out),
    .cell_valid (cell_valid),
    .fill_count (fill_count),
    .playing    (playing),
    .full       (full),
    .empty      (empty)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Returns on the negedge right after the FSM acted on the pulse.
  task automatic press(input logic st, input logic pl);
    KEY_STORE = ~st;
    KEY_PLAY  = ~pl;
    repeat (4) @(negedge CLOCK_50);
    KEY_STORE = 1'b1;
    KEY_PLAY  = 1'b1;
  endtask

  task automatic store(input logic [5:0] v);
    SW = v;
    press(1'b1, 1'b0);
    idle(3);
  endtask

  initial begin
    RESET_N   = 1'b0;
    SW        = 6'b0;
    KEY_STORE = 1'b1;
    KEY_PLAY  = 1'b1;
    for (int i = 0; i < 9; i++) pat[i] = 6'(i * 7 + 3);

    idle(2);
    check("rst_cell", 8'(cell_out), 8'h00);
    check("rst_valid", 8'(cell_valid), 8'h0);
    check("rst_fill", 8'(fill_count), 8'h0);
    check("rst_play", 8'(playing), 8'h0);
    check("rst_full", 8'(full), 8'h0);
    check("rst_empty", 8'(empty), 8'h1);
    RESET_N = 1'b1;
    idle(2);
    check("entry_valid", 8'(cell_valid), 8'h1);

    store(6'b100000);
    store(6'b101000);
    store(6'b110000);
    check("fill3", 8'(fill_count), 8'h3);
    check("fill3_empty", 8'(empty), 8'h0);
    check("fill3_full", 8'(full), 8'h0);
    SW = 6'b111000;
    idle(1);
    check("entry_echo", 8'(cell_out), 8'b111000);

    press(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) begin
        case (c)
          0: check("pb_cell0", 8'(cell_out), 8'b100000);
          1: check("pb_cell1", 8'(cell_out), 8'b101000);
          default: check("pb_cell2", 8'(cell_out), 8'b110000);
        endcase
        check("pb_playing", 8'(playing), 8'h1);
        idle(1);
      end
    end
    check("done_cell", 8'(cell_out), 8'h00);
    check("done_valid", 8'(cell_valid), 8'h0);
    check("done_play", 8'(playing), 8'h0);
    check("done_fill", 8'(fill_count), 8'h3);

    idle(3);
    press(1'b1, 1'b0);
    check("clr_fill", 8'(fill_count), 8'h0);
    check("clr_empty", 8'(empty), 8'h1);
    check("clr_valid", 8'(cell_valid), 8'h1);
    idle(3);
    press(1'b0, 1'b1);
    idle(1);
    check("empty_play", 8'(playing), 8'h0);
    check("empty_valid", 8'(cell_valid), 8'h1);

    for (int i = 0; i < 9; i++) store(pat[i]);
    check("full_fill", 8'(fill_count), 8'h8);
    check("full_flag", 8'(full), 8'h1);
    press(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("full_buf", 8'(cell_out), 8'(pat[i]));
      idle(4);
    end
    check("full_done", 8'(cell_valid), 8'h0);

    idle(2);
    press(1'b1, 1'b0);
    idle(3);
    store(6'b010101);
    store(6'b101010);
    check("pair_fill", 8'(fill_count), 8'h2);
    press(1'b1, 1'b1);
    check("both_play", 8'(playing), 8'h1);
    check("both_fill", 8'(fill_count), 8'h2);
    check("both_cell", 8'(cell_out), 8'b010101);

    idle(3);
    press(1'b0, 1'b1);
    check("abort_play", 8'(playing), 8'h0);
    check("abort_fill", 8'(fill_count), 8'h2);
    check("abort_valid", 8'(cell_valid), 8'h1);

    idle(3);
    press(1'b0, 1'b1);
    idle(1);
    check("replay", 8'(playing), 8'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_cell", 8'(cell_out), 8'h00);
    check("mid_rst_valid", 8'(cell_valid), 8'h0);
    check("mid_rst_fill", 8'(fill_count), 8'h0);
    idle(2);
    RESET_N = 1'b1;
    idle(5);
    check("post_rst_play", 8'(playing), 8'h0);
    check("post_rst_valid", 8'(cell_valid), 8'h1);
    check("post_rst_fill", 8'(fill_count), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
